// File: rtl/raw_data_chk.sv
`default_nettype none
// ============================================================================
// Module      : raw_data_chk
// Description : Raw pixel stream sink/checker. Requests pixels from the
//               upstream source, segments valid beats into lines and frames,
//               checks every pixel against an incrementing pattern and flags
//               pixel mismatches and line-length errors.
//               Optional feature macro FRAME_SUM_EN adds frame_sum_out, the
//               modulo-2^32 sum of all pixels of the last completed frame.
// Revision    : 1.0 - initial release
// ============================================================================
module raw_data_chk #(
    parameter int DATA_WIDTH  = 10,
    parameter int HSIZE       = 6,
    parameter int VSIZE       = 6,
    parameter int PATTERN_MAX = 896,
    parameter int V_GAP       = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  enable_in,
    input  logic                  clear_in,
    input  logic                  data_valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  data_req_out,
    output logic                  line_done_out,
    output logic                  frame_done_out,
    output logic [11:0]           line_cnt_out,
    output logic [11:0]           frame_cnt_out,
    output logic                  mismatch_out,
    output logic                  len_err_out,
    output logic [15:0]           err_cnt_out
`ifdef FRAME_SUM_EN
    ,
    output logic [31:0]           frame_sum_out
`endif
);

    localparam int                    c_GAP_W    = (V_GAP > 1) ? $clog2(V_GAP) : 1;
    localparam logic [c_GAP_W-1:0]    c_GAP_LAST = c_GAP_W'((V_GAP > 0) ? (V_GAP - 1) : 0);
    localparam logic [DATA_WIDTH-1:0] c_EXP_MAX  = DATA_WIDTH'(PATTERN_MAX);
    localparam logic [11:0]           c_HSIZE    = 12'(HSIZE);
    localparam logic [11:0]           c_VSIZE    = 12'(VSIZE);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_RUN       = 2'd1,
        S_FRAME_GAP = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [c_GAP_W-1:0]      r_gap_cnt;
    logic                    r_valid_d;
    logic [11:0]             r_beat_cnt;
    logic [DATA_WIDTH-1:0]   r_exp;
    logic [DATA_WIDTH-1:0]   w_exp_inc;
    logic                    w_line_end;
    logic                    w_frame_end;
    logic                    w_pix_err;

    // A line ends on the falling edge of data_valid_in; the frame ends on the
    // line that brings the line count up to VSIZE.
    assign w_line_end  = r_valid_d & ~data_valid_in;
    assign w_frame_end = w_line_end & ((line_cnt_out + 12'd1) == c_VSIZE);
    assign w_pix_err   = data_valid_in & (data_in != r_exp);
    assign w_exp_inc   = (r_exp == c_EXP_MAX) ? '0 : r_exp + DATA_WIDTH'(1);

    // State register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: a running frame always completes before stopping
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (enable_in) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_frame_end) begin
                    if (V_GAP == 0) begin
                        w_state_nxt = enable_in ? S_RUN : S_IDLE;
                    end else begin
                        w_state_nxt = S_FRAME_GAP;
                    end
                end
            end
            S_FRAME_GAP: begin
                if (r_gap_cnt == c_GAP_LAST) begin
                    w_state_nxt = enable_in ? S_RUN : S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Inter-frame gap timer, held at zero outside FRAME_GAP
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_gap_cnt <= '0;
        end else if ((r_state == S_FRAME_GAP) && (w_state_nxt == S_FRAME_GAP)) begin
            r_gap_cnt <= r_gap_cnt + c_GAP_W'(1);
        end else begin
            r_gap_cnt <= '0;
        end
    end

    // Request follows the registered state, so it rises one cycle into RUN
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            data_req_out <= 1'b0;
        end else begin
            data_req_out <= (r_state == S_RUN);
        end
    end

    // Line/frame segmentation: beat counting, line and frame counters, pulses
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_valid_d      <= 1'b0;
            r_beat_cnt     <= '0;
            line_done_out  <= 1'b0;
            frame_done_out <= 1'b0;
            line_cnt_out   <= '0;
            frame_cnt_out  <= '0;
        end else begin
            r_valid_d      <= data_valid_in;
            line_done_out  <= w_line_end;
            frame_done_out <= w_frame_end;
            if (w_line_end) begin
                r_beat_cnt <= '0;
            end else if (data_valid_in && (r_beat_cnt != 12'hFFF)) begin
                r_beat_cnt <= r_beat_cnt + 12'd1;
            end
            if (w_frame_end) begin
                line_cnt_out  <= '0;
                frame_cnt_out <= frame_cnt_out + 12'd1;
            end else if (w_line_end) begin
                line_cnt_out  <= line_cnt_out + 12'd1;
            end
        end
    end

    // Expected-pattern counter, restarted at every frame boundary
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_exp <= '0;
        end else if (w_frame_end) begin
            r_exp <= '0;
        end else if (data_valid_in) begin
            r_exp <= w_exp_inc;
        end
    end

    // Sticky error flags and saturating error count; clear takes priority
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            mismatch_out <= 1'b0;
            len_err_out  <= 1'b0;
            err_cnt_out  <= '0;
        end else if (clear_in) begin
            mismatch_out <= 1'b0;
            len_err_out  <= 1'b0;
            err_cnt_out  <= '0;
        end else begin
            if (w_pix_err) begin
                mismatch_out <= 1'b1;
                if (err_cnt_out != 16'hFFFF) begin
                    err_cnt_out <= err_cnt_out + 16'd1;
                end
            end
            if (w_line_end && (r_beat_cnt != c_HSIZE)) begin
                len_err_out <= 1'b1;
            end
        end
    end

`ifdef FRAME_SUM_EN
    logic [31:0] r_sum_acc;

    // Running pixel sum, published and restarted at each frame end
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_sum_acc     <= '0;
            frame_sum_out <= '0;
        end else if (w_frame_end) begin
            r_sum_acc     <= '0;
            frame_sum_out <= r_sum_acc;
        end else if (data_valid_in) begin
            r_sum_acc     <= r_sum_acc + 32'(data_in);
        end
    end
`endif

endmodule
`default_nettype wire
